// File: rtl/common.sv
// Types shared between the core pipeline, the register file and the load/store unit.
package common;

    typedef logic [31:0] data_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6,
        DONE    = 3'd7
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu.sv
// Per-thread load/store unit: one LDR/STR at a time over a valid/ready memory port.
// state          | meaning
// LSU_IDLE       | waiting for a REQUEST with a memory op
// LSU_REQUESTING | forming address, launching request
// LSU_WAITING    | valid held until the active channel's ready
// LSU_DONE       | complete, held until core reaches UPDATE
module lsu
    import common::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  core_state_t           core_state,
    input  logic                  decoded_mem_read_enable,
    input  logic                  decoded_mem_write_enable,
    input  data_t                 decoded_immediate,
    input  data_t                 rs1,
    input  data_t                 rs2,
    output logic                  mem_read_valid,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic                  mem_read_ready,
    input  data_t                 mem_read_data,
    output logic                  mem_write_valid,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output data_t                 mem_write_data,
    input  logic                  mem_write_ready,
    output lsu_state_t            lsu_state,
    output data_t                 lsu_out
);

    lsu_state_t            state_q, state_d;
    logic                  is_read_q, is_read_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] lsu_out_q, lsu_out_d;

    // Address wraps silently; only the low ADDR_WIDTH bits of the sum matter.
    data_t                            addr_sum;
    logic [ADDR_WIDTH-1:0]            addr;
    logic [DATA_WIDTH-ADDR_WIDTH-1:0] addr_sum_unused;

    assign addr_sum                 = rs1 + decoded_immediate;
    assign {addr_sum_unused, addr}  = addr_sum;

    always_comb begin
        state_d    = state_q;
        is_read_d  = is_read_q;
        rd_valid_d = rd_valid_q;
        wr_valid_d = wr_valid_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        lsu_out_d  = lsu_out_q;

        unique case (state_q)
            LSU_IDLE: begin
                if (enable && core_state == REQUEST &&
                    (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                    state_d   = LSU_REQUESTING;
                    // Read wins when both enables are set.
                    is_read_d = decoded_mem_read_enable;
                end
            end
            LSU_REQUESTING: begin
                if (is_read_q) begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = addr;
                end else begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = addr;
                    wr_data_d  = rs2;
                end
                state_d = LSU_WAITING;
            end
            LSU_WAITING: begin
                if (rd_valid_q && mem_read_ready) begin
                    rd_valid_d = 1'b0;
                    lsu_out_d  = mem_read_data;
                    state_d    = LSU_DONE;
                end else if (wr_valid_q && mem_write_ready) begin
                    wr_valid_d = 1'b0;
                    state_d    = LSU_DONE;
                end
            end
            LSU_DONE: begin
                if (core_state == UPDATE) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LSU_IDLE;
            is_read_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            lsu_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            is_read_q  <= is_read_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            lsu_out_q  <= lsu_out_d;
        end
    end

    assign lsu_state         = state_q;
    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = rd_addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_data    = wr_data_q;
    assign lsu_out           = lsu_out_q;

endmodule

// File: doc/lsu.md
# lsu

Per-thread load/store unit that sits directly upstream of the per-thread register file. It executes LDR and STR for one thread. It forms the address from the decoded register operands, runs a valid/ready handshake with the memory controller, and presents the loaded word on `lsu_out` for the register file's MEMORY write-back path. The core steps it through the shared core-state sequence and stalls in WAIT until the unit reports LSU_DONE.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: data-memory address width.
- `DATA_WIDTH`, 32: word width; equals `$bits(data_t)`.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `enable`  in  1: thread active in current block; gates only the start of a transaction.
- `core_state`  in  core_state_t: core pipeline state.
- `decoded_mem_read_enable`  in  1: instruction is LDR.
- `decoded_mem_write_enable`  in  1: instruction is STR.
- `decoded_immediate`  in  data_t: address offset.
- `rs1`  in  data_t: base address register value.
- `rs2`  in  data_t: store data.
- `mem_read_valid`  out  1: read request.
- `mem_read_address`  out  ADDR_WIDTH: read address.
- `mem_read_ready`  in  1: read data valid on `mem_read_data`.
- `mem_read_data`  in  data_t: returned word.
- `mem_write_valid`  out  1: write request.
- `mem_write_address`  out  ADDR_WIDTH: write address.
- `mem_write_data`  out  data_t: write word.
- `mem_write_ready`  in  1: write accepted.
- `lsu_state`  out  lsu_state_t: FSM state, observed by the core scheduler.
- `lsu_out`  out  data_t: last loaded word.

## Operation
- FSM states: LSU_IDLE, LSU_REQUESTING, LSU_WAITING, LSU_DONE.
- LSU_IDLE -> LSU_REQUESTING when all of these hold: `enable`, `core_state == REQUEST`, and a read or write enable is set.
  - Otherwise the FSM stays in LSU_IDLE.
  - If both read and write enables are set, the read wins and the write is ignored.
- LSU_REQUESTING, always lasts one cycle:
  - Compute address = (`rs1` + `decoded_immediate`) truncated to the low ADDR_WIDTH bits; wrap-around is silent.
  - Register the address onto the selected channel and assert that channel's valid.
  - For a write, also register `rs2` onto `mem_write_data`.
  - Next state is LSU_WAITING.
- LSU_WAITING:
  - Valid, address and data stay stable until the matching ready is sampled high.
  - On a read handshake: capture `mem_read_data` into `lsu_out` and deassert valid on the next edge.
  - On a write handshake: deassert valid; `lsu_out` is unchanged.
  - Next state is LSU_DONE.
  - A ready on the channel that is not active is ignored.
- LSU_DONE: hold until `core_state == UPDATE`, then return to LSU_IDLE. `lsu_out` holds its value until the next load completes.
- `enable` low mid-transaction has no effect; the transaction completes normally.
- Only one transaction is outstanding at a time; no queuing.

## Timing
- Reset values: FSM in LSU_IDLE; both valids 0; both addresses 0; `mem_write_data` 0; `lsu_out` 0.
  - Reset wins over every other input in the same cycle.
  - Reset mid-transaction drops valid on the next edge; no completion is reported.
- Cycle timeline:
  - Cycle N: the REQUEST-start condition is sampled.
  - N+1: LSU_REQUESTING.
  - N+2: valid high, address valid, FSM in LSU_WAITING.
- Latency: minimum 3 edges from the REQUEST sample to LSU_DONE, reached when ready is high in the first WAITING cycle. Every cycle ready stays low adds one cycle; there is no timeout.
- `lsu_out` updates on the same edge that enters LSU_DONE, so the register file can sample it in UPDATE.
- All outputs are registered; no combinational path from a ready input to any output.

## Structure
- Shared package `common.sv` already holds `data_t`; add to it:
  - `core_state_t`, 3 bits: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
  - `lsu_state_t`, 2 bits: LSU_IDLE=0, LSU_REQUESTING=1, LSU_WAITING=2, LSU_DONE=3.
- Single module, no sub-modules. The address adder is inline.

## Test plan
- Load, ready 0 wait cycles: `rs1`=0x10, imm=0x4, memory[0x14]=0xDEADBEEF, REQUEST on cycle 0 -> `mem_read_valid` high with address 0x14 on cycle 2; LSU_DONE on cycle 3; `lsu_out`=0xDEADBEEF; after UPDATE, FSM in LSU_IDLE.
- Store, ready delayed 4 cycles: `rs1`=0x20, imm=0, `rs2`=0x12345678 -> `mem_write_valid`, address 0x20 and data 0x12345678 held stable for 5 cycles; `lsu_out` stays 0.
- Address wrap: `rs1`=0xFF, imm=0x3, ADDR_WIDTH=8 -> address 0x02.
- Gating and priority:
  - `enable`=0 in REQUEST -> no valid asserted; FSM stays in LSU_IDLE.
  - Read and write enables both 1 -> only `mem_read_valid` asserted.
- Reset in LSU_WAITING with valid high -> next cycle: valid 0, LSU_IDLE, `lsu_out`=0; a subsequent load completes normally.
- Stray `mem_write_ready` pulse during a read -> ignored; FSM remains in LSU_WAITING until `mem_read_ready`.
